video_pixel_feeder: RTL

//  Upstream stage of the video timing generator: buffers a pixel stream from the frame store
//  (valid/ready, SOF-tagged) in a small show-ahead FIFO and answers the generator's per-pixel

---
 rtl/video_pixel_feeder_pkg.sv | 21 ++
 rtl/video_pixel_feeder_if.sv | 26 ++
 rtl/video_pixel_feeder_fifo.sv | 79 +++++++
 rtl/video_pixel_feeder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/video_pixel_feeder_pkg.sv
// Shared video definitions: pixel width, feeder state encoding, default raster size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_pixel_feeder_pkg;

    localparam int RGB_W       = 24;
    localparam int DEF_VIDEO_H = 1280;
    localparam int DEF_VIDEO_V = 720;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef enum logic {
        ST_WAIT_SOF = 1'b0,
        ST_RUN      = 1'b1
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/video_pixel_feeder_if.sv
// Frame-store pixel stream: one 24-bit pixel per beat, SOF marks a frame's first pixel.
// Latency: n/a (wires only).
// Backpressure: beat transfers when s_valid and s_ready are both high.
interface video_pixel_feeder_if;
    import video_pixel_feeder_pkg::*;

    logic s_valid;
    logic s_ready;
    rgb_t s_data;
    logic s_sof;

    modport master (
        output s_valid,
        output s_data,
        output s_sof,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_sof,
        output s_ready
    );

endinterface

// File: rtl/video_pixel_feeder_fifo.sv
// Show-ahead synchronous FIFO with registered pointers, level and full/empty flags.
// Latency: written word readable at rd_data the cycle after wr_en.
// Backpressure: writes while full and reads while empty are ignored; flush wins over both.
module sync_fifo_fwft #(
    parameter int DW = 24,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic          flush,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          full_q;
    logic          empty_q;
    logic          do_wr;
    logic          do_rd;

    assign do_wr   = wr_en && !full_q;
    assign do_rd   = rd_en && !empty_q;
    assign rd_data = mem[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            level_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            full_q  <= (level_d == FULL_LVL);
            empty_q <= (level_d == '0);
        end
    end

endmodule

// File: rtl/video_pixel_feeder.sv
// Buffers the frame-store pixel stream and answers the timing generator's pixel request combinationally.
// Latency: accepted beat visible in o_level and readable one cycle later; o_rgb same cycle as i_data_req.
// Backpressure: s_ready low when FIFO full or during a resync flush; non-SOF beats dropped while waiting for SOF.
module video_pixel_feeder
    import video_pixel_feeder_pkg::*;
#(
    parameter int VIDEO_H       = DEF_VIDEO_H,
    parameter int VIDEO_V       = DEF_VIDEO_V,
    parameter int FIFO_AW       = 4,
    parameter bit VS_SYNC_LEVEL = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_vs,
    input  logic                 i_data_req,
    output rgb_t                 o_rgb,
    video_pixel_feeder_if.slave  s,
    output logic                 o_underflow,
    output logic [15:0]          o_underflow_cnt,
    output logic [FIFO_AW:0]     o_level
);

    localparam int FRAME_PIXELS = VIDEO_H * VIDEO_V;
    localparam int PCW          = $clog2(FRAME_PIXELS) + 1;

    state_e         state_q;
    state_e         state_d;
    logic           vs_q;
    logic           frame_start;
    logic           good_frame;
    logic           flush;
    logic           ready;
    logic           fifo_wr;
    logic           fifo_rd;
    logic           fifo_full;
    logic           fifo_empty;
    rgb_t           fifo_head;
    logic           uf_ev;
    logic [PCW-1:0] pop_cnt_q;

    assign frame_start = (i_vs == VS_SYNC_LEVEL) && (vs_q != VS_SYNC_LEVEL);
    assign good_frame  = (state_q == ST_RUN) && (pop_cnt_q == PCW'(FRAME_PIXELS)) && !o_underflow;
    assign flush       = frame_start && !good_frame;

    assign fifo_rd = i_data_req && !fifo_empty;
    assign uf_ev   = i_data_req && fifo_empty && (state_q == ST_RUN);
    assign o_rgb   = fifo_rd ? fifo_head : '0;

    assign s.s_ready = ready;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        fifo_wr = 1'b0;
        case (state_q)
            ST_WAIT_SOF: begin
                ready = 1'b1;
                if (s.s_valid && s.s_sof) begin
                    fifo_wr = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                ready   = !fifo_full;
                fifo_wr = s.s_valid && !fifo_full;
            end
        endcase
        // A bad frame drops everything buffered; nothing may enter in that same cycle.
        if (flush) begin
            ready   = 1'b0;
            fifo_wr = 1'b0;
            state_d = ST_WAIT_SOF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_WAIT_SOF;
            vs_q    <= !VS_SYNC_LEVEL;
        end else begin
            state_q <= state_d;
            vs_q    <= i_vs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pop_cnt_q <= '0;
        end else if (frame_start) begin
            pop_cnt_q <= '0;
        end else if (fifo_rd && (pop_cnt_q != '1)) begin
            pop_cnt_q <= pop_cnt_q + PCW'(1);
        end
    end

    // The sticky flag covers one frame only; the counter keeps the lifetime total.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_underflow     <= 1'b0;
            o_underflow_cnt <= '0;
        end else begin
            if (frame_start) begin
                o_underflow <= uf_ev;
            end else if (uf_ev) begin
                o_underflow <= 1'b1;
            end
            if (uf_ev) begin
                o_underflow_cnt <= sat_inc16(o_underflow_cnt);
            end
        end
    end

    sync_fifo_fwft #(
        .DW (RGB_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_en   (fifo_wr),
        .wr_data (s.s_data),
        .rd_en   (fifo_rd),
        .flush   (flush),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_level)
    );

endmodule
